pll_tick_gen: RTL

Lock-qualified, parametrised rate generator that sits directly behind the iCE40 PLL wrapper, in the 50.25 MHz global clock domain. It synchronises the PLL lock flag and holds downstream logic off until lock has been stable for a programmable settle time. It then produces single-cycle tick enables at one of four run-time-selectable fractional rates, using a phase accumulator (step/bit-cell timing for the floppy drive). Loss of lock is detected, reported sticky, and forces a clean re-settle.

---
 rtl/pll_tick_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/pll_tick_gen.sv
// pll_tick_gen: lock-qualified fractional tick generator; define PLL_TICK_COUNT_EN to build the tick counter
module pll_tick_gen #(
    parameter int          ACC_WIDTH   = 24,
    parameter int unsigned INC0        = 83469,
    parameter int unsigned INC1        = 100163,
    parameter int unsigned INC2        = 166938,
    parameter int unsigned INC3        = 333875,
    parameter int          LOCK_CYCLES = 1024,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        locked,
    input  logic        enable,
    input  logic [1:0]  rate_sel,
    input  logic        clear_lost,
    output logic        ready,
    output logic        tick,
    output logic        lock_lost,
    output logic [15:0] tick_count
);
    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN, LOST} state_t;
    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [ACC_WIDTH-1:0]   r_acc, r_inc, w_sel_inc;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   r_tick, r_lost;
    logic                   w_locked_s, w_settled, w_stay_run, w_run_entry, w_advance, w_carry, w_load, w_loss;
    assign w_locked_s  = r_sync[SYNC_STAGES-1];
    assign w_settled   = r_cnt == CW'(LOCK_CYCLES - 1);
    assign w_stay_run  = (r_state == RUN) && (w_next == RUN);
    assign w_run_entry = (r_state != RUN) && (w_next == RUN);
    assign w_advance   = w_stay_run && enable;
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry     = w_advance && w_sum[ACC_WIDTH];
    assign w_load      = w_run_entry || !enable || w_carry;
    assign w_loss      = (r_state == RUN) && !w_locked_s;
    assign w_sel_inc   = (rate_sel == 2'd0) ? ACC_WIDTH'(INC0) :
                         (rate_sel == 2'd1) ? ACC_WIDTH'(INC1) :
                         (rate_sel == 2'd2) ? ACC_WIDTH'(INC2) : ACC_WIDTH'(INC3);
    assign ready       = r_state == RUN;
    assign tick        = r_tick;
    assign lock_lost   = r_lost;
    // shift the raw lock flag through the synchroniser chain
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
    // state register and settle counter (held at zero outside SETTLE)
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SETTLE) ? r_cnt + 1'b1 : '0;
        end
    end
    // next-state: any loss of synchronised lock aborts settling or running
    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_LOCK: w_next = w_locked_s ? SETTLE : WAIT_LOCK;
            SETTLE:    w_next = !w_locked_s ? WAIT_LOCK : (w_settled ? RUN : SETTLE);
            RUN:       w_next = w_locked_s ? RUN : LOST;
            LOST:      w_next = w_locked_s ? SETTLE : LOST;
            default:   w_next = WAIT_LOCK;
        endcase
    end
    // phase accumulator; new rates load only at a period boundary so no period is distorted
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
            r_inc  <= ACC_WIDTH'(INC0);
        end else begin
            r_acc  <= w_advance ? w_sum[ACC_WIDTH-1:0] : (w_stay_run ? r_acc : '0);
            r_tick <= w_carry;
            if (w_load) r_inc <= w_sel_inc;
        end
    end
    // sticky loss flag; a new loss outranks a simultaneous clear
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) r_lost <= 1'b0;
        else       r_lost <= w_loss || (r_lost && !clear_lost);
    end
`ifdef PLL_TICK_COUNT_EN
    logic [15:0] r_tcnt;
    // count cycles with tick high, restarting on every entry to RUN
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) r_tcnt <= '0;
        else       r_tcnt <= w_run_entry ? 16'd0 : r_tcnt + {15'd0, r_tick};
    end
    assign tick_count = r_tcnt;
`else
    assign tick_count = 16'd0;
`endif
endmodule
